// File: rtl/qgemm_dequant_stream.sv
// qgemm_dequant_stream: converts a tile of zero-point-corrected signed integer
// GEMM accumulators into IEEE-754 fp32, scaled by scale_A*scale_B (Q8.8 each).
// A three-stage valid/ready pipeline performs scale multiply, normalize, and
// round/pack. The FSM counts one tile of VLEN*VLEN inputs and pulses done once
// the final result has been handed off.
module qgemm_dequant_stream #(
  parameter int VLEN    = 8,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int FP_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCALE_W-1:0] scale_A,
  input  logic [SCALE_W-1:0] scale_B,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_W-1:0]    out_data,
  output logic               out_last,
  output logic               done
);

  localparam int N_ELEM  = VLEN * VLEN;
  localparam int CNT_W   = $clog2(N_ELEM + 1);
  localparam int S_W     = 2 * SCALE_W;   // combined scale, Q16.16
  localparam int PROD_W  = 64;            // |acc| * S product width
  localparam int P_W     = 6;             // index of MSB within the product
  localparam int MANT_W  = 23;
  localparam int GUARD_B = PROD_W - 2 - MANT_W;
  // p - 16 + 127: the product carries 16 fraction bits from the scale.
  localparam logic [7:0] EXP_OFS = 8'd111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [S_W-1:0]     scale_s;

  logic               s1_valid, s1_sign, s1_last;
  logic [PROD_W-1:0]  s1_m;
  logic               s2_valid, s2_sign, s2_last, s2_zero;
  logic [P_W-1:0]     s2_p;
  logic [PROD_W-1:0]  s2_norm;
  logic               s3_valid, s3_last;
  logic [FP_W-1:0]    s3_data;

  logic               s1_ready, s2_ready, s3_ready;
  logic               in_fire, out_fire;
  logic [ACC_W-1:0]   acc_mag;
  logic [P_W-1:0]     msb;
  logic [MANT_W:0]    mant_sum;
  logic               round_up;
  logic [7:0]         exp_f;
  logic [FP_W-1:0]    packed_fp;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign s3_ready  = !s3_valid || out_ready;
  assign s2_ready  = !s2_valid || s3_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = (state == RUN) && s1_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s3_valid && out_ready;
  assign out_valid = s3_valid;
  assign out_data  = s3_data;
  assign out_last  = s3_last;

  // Magnitude kept in ACC_W unsigned bits so the most negative value maps to 2^(ACC_W-1).
  assign acc_mag = in_acc[ACC_W-1] ? (~in_acc + 1'b1) : in_acc;

  // Tile control: latch the scale product, count accepted inputs, flag completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      scale_s <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished tile and is dropped.
          if (start && !done) begin
            scale_s <= S_W'(scale_A) * S_W'(scale_B);
            count   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            count <= count + 1'b1;
            if (count == CNT_W'(N_ELEM - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire && s3_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: split sign, scale the magnitude, tag the tile's final element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_last  <= 1'b0;
      s1_m     <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_sign <= in_acc[ACC_W-1];
        s1_last <= (count == CNT_W'(N_ELEM - 1));
        s1_m    <= PROD_W'(acc_mag) * PROD_W'(scale_s);
      end
    end
  end

  // Priority encoder: position of the leading one in the stage-1 product.
  always_comb begin
    // NOTE: default assignment before the loop keeps this purely combinational (no latch).
    msb = '0;
    for (int i = 0; i < PROD_W; i++) begin
      if (s1_m[i]) msb = P_W'(i);
    end
  end

  // Stage 2: detect zero and left-normalize so the leading one sits at the top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_last  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_p     <= '0;
      s2_norm  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_last <= s1_last;
        s2_zero <= (s1_m == '0);
        s2_p    <= msb;
        s2_norm <= s1_m << (P_W'(PROD_W - 1) - msb);
      end
    end
  end

  // Round-to-nearest-even on guard + sticky; a mantissa carry bumps the exponent.
  assign round_up  = s2_norm[GUARD_B] &&
                     ((|s2_norm[GUARD_B-1:0]) || s2_norm[GUARD_B+1]);
  assign mant_sum  = {1'b0, s2_norm[PROD_W-2 -: MANT_W]} + (MANT_W+1)'(round_up);
  assign exp_f     = 8'(s2_p) + EXP_OFS + 8'(mant_sum[MANT_W]);
  assign packed_fp = s2_zero ? '0 : {s2_sign, exp_f, mant_sum[MANT_W-1:0]};

  // Stage 3: output register; holds steady while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well because out_data must read zero after reset.
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_data  <= '0;
    end else if (s3_ready) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_last <= s2_last;
        s3_data <= packed_fp;
      end
    end
  end

endmodule

// File: tb/tb_qgemm_dequant_stream.sv
// Self-checking bench for qgemm_dequant_stream: directed test-plan values,
// randomized tiles against an arithmetic fp32 reference, backpressure,
// ignored mid-tile start, and asynchronous reset mid-tile.
module tb_qgemm_dequant_stream;

  localparam int VLEN = 8;
  localparam int N    = VLEN * VLEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] scale_a = '0, scale_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_acc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_s;
  logic [31:0] acc_vec[N];
  logic [31:0] got[N];

  qgemm_dequant_stream #(.VLEN(VLEN), .ACC_W(32), .SCALE_W(16), .FP_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scale_A(scale_a), .scale_B(scale_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact value |acc|*S / 2^16 rounded to fp32 with round-half-even, by integer arithmetic.
  function automatic logic [31:0] ref_fp(input logic [31:0] acc, input logic [31:0] s);
    longint unsigned mag, x, q, r, half;
    int e;
    logic sgn;
    sgn = acc[31];
    mag = sgn ? (64'h1_0000_0000 - 64'(acc)) : 64'(acc);
    x   = mag * 64'(s);
    if (x == 0) return 32'h0;
    e = 63;
    while ((x >> e) == 0) e--;
    if (e <= 23) begin
      q = x << (23 - e);
    end else begin
      q    = x >> (e - 23);
      r    = x - (q << (e - 23));
      half = 64'd1 << (e - 24);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {sgn, 8'(e - 16 + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_acc();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) acc_vec[i] = rand_acc();
  endtask

  task automatic do_start(input logic [15:0] sa, input logic [15:0] sb);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("in_ready_idle", in_ready, 1'b0);
    start   = 1'b1;
    scale_a = sa;
    scale_b = sb;
    cur_s   = {16'd0, sa} * {16'd0, sb};
    @(negedge clk);
    start = 1'b0;
    #1;
    check("in_ready_run", in_ready, 1'b1);
  endtask

  // ready_mode: 0 always ready, 1 toggle 1/0, 2 random. valid_mode: 0 constant, 1 random gaps.
  task automatic run_tile(input int ready_mode, input int valid_mode, input bit mid_start,
                          input int abort_after);
    int   n_in = 0, n_out = 0, cyc = 0, done_cnt = 0;
    int   acc_cyc[N];
    bit   prev_stall = 0, done_due = 0, finished = 0, aborted = 0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    bit   acc_hs, out_hs;
    for (int i = 0; i < N; i++) got[i] = '0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      start     = mid_start && (cyc == 5);
      scale_a   = 16'($urandom);
      scale_b   = 16'($urandom);
      in_valid  = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_acc    = (n_in < N) ? acc_vec[n_in] : $urandom;
      out_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      check("done", done, done_due);
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (n_in >= N) check("in_ready_low", in_ready, 1'b0);
      acc_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      done_due = 1'b0;
      if (out_hs) begin
        if (n_out < N) begin
          check("data", out_data, ref_fp(acc_vec[n_out], cur_s));
          check("last", out_last, n_out == N - 1);
          if (ready_mode == 0) check("latency", cyc - acc_cyc[n_out], 3);
          got[n_out] = out_data;
        end else begin
          check("extra_out", n_out, N - 1);
        end
        n_out++;
        done_due = (n_out == N);
      end
      if (acc_hs) begin
        if (n_in < N) acc_cyc[n_in] = cyc;
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) finished = 1;
      if (abort_after > 0 && n_in == abort_after) begin
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        aborted = 1;
        break;
      end
      cyc++;
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_count", done_cnt, 1);
      check("out_count", n_out, N);
      check("in_count", n_in, N);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("done_width", done, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_done", done, 1'b0);
    rst_n = 1'b1;

    // S = 1.0: basic values and rounding ties
    fill_random();
    acc_vec[0] = 32'h0000_0001;
    acc_vec[1] = 32'hFFFF_FFFE;
    acc_vec[2] = 32'h0000_0000;
    acc_vec[3] = 32'h7FFF_FFFF;
    acc_vec[4] = 32'h0100_0001;
    acc_vec[5] = 32'h0100_0003;
    acc_vec[6] = 32'h0100_0005;
    do_start(16'h0100, 16'h0100);
    run_tile(0, 0, 0, 0);
    check("tp_one",      got[0], 32'h3F80_0000);
    check("tp_minus_two", got[1], 32'hC000_0000);
    check("tp_zero",     got[2], 32'h0000_0000);
    check("tp_max_pos",  got[3], 32'h4F00_0000);
    check("tp_tie_even", got[4], 32'h4B80_0000);
    check("tp_tie_up",   got[5], 32'h4B80_0002);
    check("tp_tie_even2", got[6], 32'h4B80_0002);

    // S = 0.25: fraction and most negative accumulator, random input gaps
    fill_random();
    acc_vec[0] = 32'h0000_0003;
    acc_vec[1] = 32'h8000_0000;
    do_start(16'h0080, 16'h0080);
    run_tile(0, 1, 0, 0);
    check("tp_three_quarter", got[0], 32'h3F40_0000);
    check("tp_most_neg",      got[1], 32'hCE00_0000);

    // Full tile with toggling out_ready and an ignored mid-tile start
    fill_random();
    do_start(16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 16'hFFFF)));
    run_tile(1, 0, 1, 0);

    // Second tile after done uses the new scales; random backpressure
    fill_random();
    do_start(16'h0340, 16'h0123);
    run_tile(2, 1, 0, 0);

    // Zero scale gives +0.0 everywhere
    fill_random();
    do_start(16'h0000, 16'($urandom));
    run_tile(2, 0, 0, 0);

    // Asynchronous reset after 10 accepted inputs, then a fresh tile
    fill_random();
    do_start(16'h0155, 16'h00F3);
    run_tile(0, 0, 0, 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("post_rst_done", done, 1'b0);
      check("post_rst_valid", out_valid, 1'b0);
    end
    fill_random();
    do_start(16'($urandom), 16'($urandom));
    run_tile(1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
